// File: rtl/bidir_bus_pkg.sv
// Shared types and constants for the bidir bus sequencer.
package bidir_bus_pkg;

   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_TURN  = 2'd1,
      ST_WRITE = 2'd2,
      ST_READ  = 2'd3
   } state_e;

   typedef enum logic {
      DIR_READ  = 1'b0,
      DIR_WRITE = 1'b1
   } dir_e;

   // A timed state lasting N cycles loads N-1; it ends on the cycle the count reads 0.
   function automatic logic [CNT_W-1:0] cnt_load(input int cyc);
      return CNT_W'(cyc - 1);
   endfunction

endpackage

// File: rtl/bus_turn_timer.sv
// Loadable saturating down counter shared by the TURN/WRITE/READ states.
module bus_turn_timer
   import bidir_bus_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             done
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Load takes priority; otherwise count down and hold at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load)
         cnt_d = load_val;
      else if (cnt_q != '0)
         cnt_d = cnt_q - CNT_W'(1);
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign done = (cnt_q == '0);

endmodule

// File: rtl/bidir_bus_sequencer.sv
// Sequencer/arbiter for a half-duplex bus behind a bidir_buffer.
// Round-robin between a write client and a read client, with a ctrl=0
// turnaround gap on every direction change; the bus parks in the last direction.
module bidir_bus_sequencer
   import bidir_bus_pkg::*;
#(
   parameter int W          = 8,
   parameter int TURN_CYC   = 1,
   parameter int HOLD_CYC   = 2,
   parameter int SAMPLE_CYC = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         wr_valid,
   input  logic [W-1:0] wr_data,
   output logic         wr_ready,
   input  logic         rd_req,
   output logic [W-1:0] rd_data,
   output logic         rd_valid,
   output logic         ctrl,
   output logic [W-1:0] data_in,
   input  logic [W-1:0] data_out,
   output logic         busy
);

   if (TURN_CYC < 1 || TURN_CYC > 15 || HOLD_CYC < 1 || HOLD_CYC > 15 ||
       SAMPLE_CYC < 1 || SAMPLE_CYC > 15) begin : g_bad_param
      $error("bidir_bus_sequencer: cycle parameters must be in 1..15");
   end

   state_e         state_q, state_d;
   dir_e           dir_q, dir_d;
   dir_e           last_grant_q, last_grant_d;
   logic           ctrl_q, ctrl_d;
   logic [W-1:0]   data_in_q, data_in_d;
   logic [W-1:0]   rd_data_q, rd_data_d;
   logic           rd_valid_q, rd_valid_d;

   logic             tmr_load;
   logic [CNT_W-1:0] tmr_val;
   logic             tmr_done;
   logic             wr_win, rd_win;

   bus_turn_timer u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .done     (tmr_done)
   );

   // Round-robin: a lone requester wins; on a tie the side not granted last wins.
   always_comb begin
      wr_win = wr_valid & (~rd_req | (last_grant_q == DIR_READ));
      rd_win = rd_req   & (~wr_valid | (last_grant_q == DIR_WRITE));
   end

   assign wr_ready = ~rst & (state_q == ST_IDLE) & wr_win;
   assign busy     = (state_q != ST_IDLE);
   assign ctrl     = ctrl_q;
   assign data_in  = data_in_q;
   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;

   // Next-state and registered-output logic.
   always_comb begin
      state_d      = state_q;
      dir_d        = dir_q;
      last_grant_d = last_grant_q;
      ctrl_d       = ctrl_q;
      data_in_d    = data_in_q;
      rd_data_d    = rd_data_q;
      rd_valid_d   = 1'b0;
      tmr_load     = 1'b0;
      tmr_val      = '0;
      unique case (state_q)
         ST_IDLE: begin
            if (wr_win) begin
               data_in_d    = wr_data;
               last_grant_d = DIR_WRITE;
               tmr_load     = 1'b1;
               if (dir_q == DIR_WRITE) begin
                  state_d = ST_WRITE;
                  tmr_val = cnt_load(HOLD_CYC);
               end else begin
                  state_d = ST_TURN;
                  tmr_val = cnt_load(TURN_CYC);
               end
            end else if (rd_win) begin
               last_grant_d = DIR_READ;
               tmr_load     = 1'b1;
               if (dir_q == DIR_READ) begin
                  state_d = ST_READ;
                  tmr_val = cnt_load(SAMPLE_CYC);
               end else begin
                  ctrl_d  = 1'b0;
                  state_d = ST_TURN;
                  tmr_val = cnt_load(TURN_CYC);
               end
            end
         end
         ST_TURN: begin
            ctrl_d = 1'b0;
            if (tmr_done) begin
               tmr_load = 1'b1;
               if (dir_q == DIR_READ) begin
                  dir_d   = DIR_WRITE;
                  ctrl_d  = 1'b1;
                  state_d = ST_WRITE;
                  tmr_val = cnt_load(HOLD_CYC);
               end else begin
                  dir_d   = DIR_READ;
                  state_d = ST_READ;
                  tmr_val = cnt_load(SAMPLE_CYC);
               end
            end
         end
         ST_WRITE: begin
            // ctrl stays high on exit so the bus parks in the write direction
            ctrl_d = 1'b1;
            if (tmr_done)
               state_d = ST_IDLE;
         end
         ST_READ: begin
            ctrl_d = 1'b0;
            if (tmr_done) begin
               rd_data_d  = data_out;
               rd_valid_d = 1'b1;
               state_d    = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         dir_q        <= DIR_READ;
         last_grant_q <= DIR_READ;
         ctrl_q       <= 1'b0;
         data_in_q    <= '0;
         rd_data_q    <= '0;
         rd_valid_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         dir_q        <= dir_d;
         last_grant_q <= last_grant_d;
         ctrl_q       <= ctrl_d;
         data_in_q    <= data_in_d;
         rd_data_q    <= rd_data_d;
         rd_valid_q   <= rd_valid_d;
      end
   end

endmodule

// File: tb/tb_bidir_bus_sequencer.sv
// Directed bench for bidir_bus_sequencer with an inline bidir_buffer model:
// the external device drives the bus whenever ctrl=0.
module tb_bidir_bus_sequencer;

   localparam int W      = 8;
   localparam int TURN   = 1;
   localparam int HOLD   = 2;
   localparam int SAMPLE = 1;

   logic         clk = 1'b0;
   logic         rst;
   logic         wr_valid;
   logic [W-1:0] wr_data;
   logic         wr_ready;
   logic         rd_req;
   logic [W-1:0] rd_data;
   logic         rd_valid;
   logic         ctrl;
   logic [W-1:0] data_in;
   logic [W-1:0] data_out;
   logic         busy;
   logic [W-1:0] ext_data;
   logic [W-1:0] bus;

   int n_run  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   assign bus      = ctrl ? data_in : ext_data;
   assign data_out = bus;

   bidir_bus_sequencer #(
      .W(W), .TURN_CYC(TURN), .HOLD_CYC(HOLD), .SAMPLE_CYC(SAMPLE)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .wr_valid (wr_valid),
      .wr_data  (wr_data),
      .wr_ready (wr_ready),
      .rd_req   (rd_req),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .ctrl     (ctrl),
      .data_in  (data_in),
      .data_out (data_out),
      .busy     (busy)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // Turnaround invariant: every ctrl rise and every read sample follows >= TURN idle cycles.
   int   zero_run  = TURN;
   logic prev_ctrl = 1'b0;
   always @(negedge clk) begin
      if (rst) begin
         zero_run  <= TURN;
         prev_ctrl <= 1'b0;
      end else begin
         if (ctrl && !prev_ctrl)
            chk("turn_gap", 32'(zero_run >= TURN), 32'd1);
         if (rd_valid) begin
            chk("rd_known", 32'($isunknown(rd_data)), 32'd0);
            chk("sample_gap", 32'(zero_run >= TURN), 32'd1);
         end
         zero_run  <= ctrl ? 0 : zero_run + 1;
         prev_ctrl <= ctrl;
      end
   end

   logic [7:0] seq;
   int         n_wr, n_rd;

   initial begin
      rst      = 1'b1;
      wr_valid = 1'b1;
      wr_data  = 8'hA5;
      rd_req   = 1'b0;
      ext_data = 8'h5A;

      // 1: reset with a pending write
      step; step;
      chk("rst_ctrl",     32'(ctrl),     32'd0);
      chk("rst_wr_ready", 32'(wr_ready), 32'd0);
      chk("rst_rd_valid", 32'(rd_valid), 32'd0);
      chk("rst_busy",     32'(busy),     32'd0);
      rst      = 1'b0;
      wr_valid = 1'b0;
      step;

      // 2: write after reset needs one TURN cycle
      wr_valid = 1'b1;
      wr_data  = 8'hA5;
      #1;
      chk("w1_ready", 32'(wr_ready), 32'd1);
      step;
      chk("w1_turn_ctrl", 32'(ctrl),     32'd0);
      chk("w1_busy",      32'(busy),     32'd1);
      chk("w1_ready_off", 32'(wr_ready), 32'd0);
      wr_valid = 1'b0;
      step;
      chk("w1_c1_ctrl", 32'(ctrl), 32'd1);
      chk("w1_c1_bus",  32'(bus),  32'hA5);
      step;
      chk("w1_c2_ctrl", 32'(ctrl), 32'd1);
      chk("w1_c2_bus",  32'(bus),  32'hA5);
      step;
      chk("w1_idle_busy", 32'(busy), 32'd0);
      chk("w1_park_ctrl", 32'(ctrl), 32'd1);

      // 3: back-to-back writes, no turnaround
      wr_valid = 1'b1;
      wr_data  = 8'hA5;
      #1;
      chk("w2_ready", 32'(wr_ready), 32'd1);
      step;
      chk("w2_ctrl", 32'(ctrl), 32'd1);
      chk("w2_bus",  32'(bus),  32'hA5);
      chk("w2_busy", 32'(busy), 32'd1);
      wr_data = 8'h3C;
      #1;
      chk("w2_busy_ready", 32'(wr_ready), 32'd0);
      step;
      chk("w2_c2_bus", 32'(bus), 32'hA5);
      step;
      chk("w2_idle_busy", 32'(busy), 32'd0);
      chk("w2_park_ctrl", 32'(ctrl), 32'd1);
      chk("w3_ready",     32'(wr_ready), 32'd1);
      step;
      chk("w3_ctrl", 32'(ctrl), 32'd1);
      chk("w3_bus",  32'(bus),  32'h3C);
      wr_valid = 1'b0;
      step;
      chk("w3_c2_ctrl", 32'(ctrl), 32'd1);
      step;
      chk("w3_idle_busy", 32'(busy), 32'd0);

      // 4: read after write: turnaround then one sample cycle
      ext_data = 8'h5A;
      rd_req   = 1'b1;
      step;
      chk("r1_ctrl",  32'(ctrl),     32'd0);
      chk("r1_v0",    32'(rd_valid), 32'd0);
      step;
      chk("r1_v1",    32'(rd_valid), 32'd0);
      chk("r1_ctrl2", 32'(ctrl),     32'd0);
      step;
      chk("r1_valid", 32'(rd_valid), 32'd1);
      chk("r1_data",  32'(rd_data),  32'h5A);
      chk("r1_busy",  32'(busy),     32'd0);
      rd_req = 1'b0;
      step;
      chk("r1_pulse", 32'(rd_valid), 32'd0);

      // same-direction read: SAMPLE cycles only
      ext_data = 8'hC3;
      rd_req   = 1'b1;
      step;
      chk("r2_v0", 32'(rd_valid), 32'd0);
      step;
      chk("r2_valid", 32'(rd_valid), 32'd1);
      chk("r2_data",  32'(rd_data),  32'hC3);
      rd_req = 1'b0;
      step;

      // 5: tie, both held: grants alternate W,R,W,R
      ext_data = 8'h5A;
      wr_data  = 8'h11;
      wr_valid = 1'b1;
      rd_req   = 1'b1;
      seq      = 8'h00;
      n_wr     = 0;
      n_rd     = 0;
      #1;
      for (int i = 0; i < 14; i++) begin
         if (wr_ready) begin
            seq  = {seq[5:0], 2'b01};
            n_wr++;
         end
         step;
         if (n_wr > 0 && !busy && rd_valid == 1'b0 && i < 13) wr_data = wr_data;
         if (rd_valid) begin
            seq = {seq[5:0], 2'b10};
            n_rd++;
            chk("tie_rd_data", 32'(rd_data), 32'h5A);
         end
         if (busy && !rd_valid) wr_data = 8'h11 + 8'(n_wr * 8'h11);
      end
      chk("tie_order", 32'(seq), 32'h66);
      chk("tie_nwr",   32'(n_wr), 32'd2);
      chk("tie_nrd",   32'(n_rd), 32'd2);
      wr_valid = 1'b0;
      rd_req   = 1'b0;
      step;
      chk("tie_end_busy",  32'(busy),     32'd0);
      chk("tie_end_pulse", 32'(rd_valid), 32'd0);

      // 6: reset in the middle of a read
      rd_req = 1'b1;
      step;
      chk("r3_busy", 32'(busy), 32'd1);
      rst    = 1'b1;
      rd_req = 1'b0;
      step;
      chk("rst_mid_valid", 32'(rd_valid), 32'd0);
      chk("rst_mid_ctrl",  32'(ctrl),     32'd0);
      chk("rst_mid_busy",  32'(busy),     32'd0);
      rst = 1'b0;
      step;
      chk("rst_after_valid", 32'(rd_valid), 32'd0);

      // rd_req withdrawn before grant yields nothing
      wr_valid = 1'b1;
      wr_data  = 8'h77;
      step;
      wr_valid = 1'b0;
      rd_req   = 1'b1;
      step;
      rd_req = 1'b0;
      step; step; step;
      chk("drop_rd_valid", 32'(rd_valid), 32'd0);
      chk("drop_busy",     32'(busy),     32'd0);
      chk("drop_ctrl",     32'(ctrl),     32'd1);
      chk("drop_data_in",  32'(data_in),  32'h77);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
